audio_ctrl: RTL and testbench
=============================

# audio_ctrl

Mode controller and playback address sequencer for the lab3 audio path. Turns single-cycle key pulses into start/pause/stop commands for the I2S recorder and the player. Latches the recorded length when recording ends. During playback it generates the SRAM read address once per LRC frame, with fast (skip) and slow (repeat) speed modes. Sits between the key debouncers and the recorder/player/SRAM mux in the audio top level.

## Interface
- ADDR_W, 20, SRAM word address width
- MAX_ADDR, 20'hFFFFF, last writable address; recording auto-stops here
- i_clk  in  1  BCLK domain clock
- i_rst_n  in  1  synchronous reset, active-high (despite the name)
- i_lrc  in  1  I2S LR clock, sampled on i_clk
- i_key_rec, i_key_play, i_key_pause, i_key_stop  in  1 each  single-cycle command pulses
- i_fast, i_slow  in  1 each  speed mode select
- i_speed  in  3  speed factor minus one (0 = 1x … 7 = 8x)
- i_rec_addr  in  ADDR_W  recorder's current write address
- o_state  out  3  current FSM state (package encoding)
- o_rec_start, o_rec_pause, o_rec_stop  out  1 each  one-cycle recorder commands
- o_play_en  out  1  high in PLAY
- o_play_addr  out  ADDR_W  playback read address
- o_sample_tick  out  1  one-cycle pulse when o_play_addr takes a new value
- o_last_addr  out  ADDR_W  exclusive end of the recording
- o_sram_we  out  1  high in REC and REC_PAUSE (recorder owns the SRAM)

## Operation
- States: IDLE, REC, REC_PAUSE, PLAY, PLAY_PAUSE.
- Simultaneous keys are resolved by priority: stop > pause > rec > play.
- IDLE
  - rec → REC, with o_rec_start.
  - play → PLAY if o_last_addr != 0; otherwise ignored.
- REC
  - pause → REC_PAUSE, with o_rec_pause.
  - stop, or i_rec_addr == MAX_ADDR → IDLE, with o_rec_stop; latch o_last_addr <= i_rec_addr.
  - play ignored.
- REC_PAUSE
  - rec or pause → REC, with o_rec_start.
  - stop → IDLE, same latch as in REC.
- PLAY
  - pause → PLAY_PAUSE, holding the address and repeat counter.
  - stop → IDLE; o_play_addr <= 0, repeat counter <= 0.
  - rec ignored.
- PLAY_PAUSE
  - play or pause → PLAY.
  - stop → as in PLAY.
- Frame tick: i_lrc high and lrc_d (registered i_lrc) low, evaluated only in PLAY.
- Address advance on each tick:
  - Normal mode (neither or both of i_fast/i_slow set): next = addr + 1.
  - Fast: next = addr + i_speed + 1, computed in ADDR_W+1 bits, so no wrap.
  - Slow: if rep_cnt == i_speed, then next = addr + 1 and rep_cnt <= 0; else hold addr and rep_cnt++. o_sample_tick still pulses on a hold, because the player re-reads the sample.
- End of playback: if next >= o_last_addr → IDLE, o_play_addr <= 0, no o_sample_tick.
- Speed inputs are read at every tick; a change takes effect on the next tick.
- Entering PLAY from IDLE always starts at address 0 with rep_cnt 0.

## Timing
- Reset: state IDLE, all command pulses 0, o_play_addr 0, o_last_addr 0, rep_cnt 0, lrc_d 0, o_sram_we 0, o_play_en 0.
- Reset mid-operation: same values in one cycle; a REC in progress does not update o_last_addr.
- Key pulse in cycle n → state change and command pulse in cycle n+1; each command is exactly one cycle.
- i_lrc rises in cycle n (lrc_d low) → o_play_addr updated and o_sample_tick high in cycle n+1.
- Auto-stop at MAX_ADDR behaves exactly like i_key_stop; it takes precedence over a same-cycle pause.
- A stop in the same cycle as a frame tick wins: the address resets and no tick is emitted.

## Structure
- audio_ctrl_pkg holds:
  - the state enum, 3-bit encoding IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4;
  - ADDR_W and MAX_ADDR defaults;
  - the speed-mode enum (NORMAL, FAST, SLOW).
- Sub-module play_addr_gen holds the LRC edge detect, repeat counter, next-address arithmetic and end compare. Its interface is tick-in/enable/clear and addr/tick/done out.
- audio_ctrl keeps the FSM, the command pulses and the o_last_addr latch.

## Test plan
- Record: rec pulse; i_rec_addr ramps to 20'd100; stop → o_rec_start then o_rec_stop one cycle each, o_last_addr = 100, state IDLE, o_sram_we low.
- Normal play with last=100: play; 100 LRC rising edges → addresses 1..99 each with o_sample_tick; the 100th edge returns to IDLE with addr 0 and no tick.
- Fast, i_speed=3, last=100: addresses 4, 8, …, 96; the next edge (100 ≥ last) ends playback. Slow, i_speed=1: 0, 1, 1, 2, 2 … with a tick every edge.
- Pause/resume: pause at addr 10 during PLAY; 5 LRC edges → addr stays 10; play → next edge gives 11. Pause in REC → o_rec_pause, then rec → o_rec_start.
- Simultaneous stop+pause+rec in REC → IDLE with o_rec_stop only. i_rec_addr = 20'hFFFFF with no key → auto-stop, o_last_addr = 20'hFFFFF.
- Play with o_last_addr = 0 → stays IDLE. Reset asserted in PLAY at addr 50 → next cycle IDLE, addr 0, o_last_addr 0.

Source files
------------

// File: rtl/audio_ctrl_pkg.sv
// Shared types and defaults for the lab3 audio mode controller and playback sequencer.
package audio_ctrl_pkg;

   localparam int               DEF_ADDR_W   = 20;
   localparam logic [19:0]      DEF_MAX_ADDR = 20'hFFFFF;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      REC        = 3'd1,
      REC_PAUSE  = 3'd2,
      PLAY       = 3'd3,
      PLAY_PAUSE = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      NORMAL,
      FAST,
      SLOW
   } speed_mode_t;

   // Only the highest-priority key of a cycle is acted on.
   typedef enum logic [2:0] {
      KEY_NONE,
      KEY_STOP,
      KEY_PAUSE,
      KEY_REC,
      KEY_PLAY
   } key_t;

   function automatic speed_mode_t decode_mode(input logic fast, input logic slow);
      if (fast && !slow)      return FAST;
      else if (slow && !fast) return SLOW;
      else                    return NORMAL;
   endfunction

   function automatic key_t decode_key(input logic stop, input logic pause,
                                       input logic rec,  input logic play);
      if (stop)       return KEY_STOP;
      else if (pause) return KEY_PAUSE;
      else if (rec)   return KEY_REC;
      else if (play)  return KEY_PLAY;
      else            return KEY_NONE;
   endfunction

endpackage

// File: rtl/play_addr_gen.sv
// Playback read-address generator: one step per LRC rising edge, with skip (fast)
// and repeat (slow) modes, and an end-of-recording compare.
module play_addr_gen
   import audio_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lrc,
   input  logic              en,
   input  logic              clr,
   input  speed_mode_t       mode,
   input  logic [2:0]        speed,
   input  logic [ADDR_W-1:0] last,
   output logic [ADDR_W-1:0] addr,
   output logic              tick,
   output logic              done
);

   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

   logic              lrc_d;
   logic              frame;
   logic [2:0]        rep_cnt;
   logic [2:0]        rep_nx;
   logic [ADDR_W:0]   addr_ext;
   logic [ADDR_W:0]   speed_ext;
   logic [ADDR_W:0]   addr_nx;

   assign frame     = en & lrc & ~lrc_d;
   assign addr_ext  = {1'b0, addr};
   assign speed_ext = {{(ADDR_W-2){1'b0}}, speed};

   // One bit of headroom so a fast skip past the top can never wrap below last.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      addr_nx = addr_ext + ONE;
      rep_nx  = rep_cnt;
      unique case (mode)
         FAST: addr_nx = addr_ext + speed_ext + ONE;
         SLOW: begin
            if (rep_cnt == speed) begin
               rep_nx = 3'd0;
            end else begin
               addr_nx = addr_ext;
               rep_nx  = rep_cnt + 3'd1;
            end
         end
         default: ;
      endcase
   end

   assign done = frame & (addr_nx >= {1'b0, last});

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         lrc_d   <= 1'b0;
         addr    <= '0;
         rep_cnt <= 3'd0;
         tick    <= 1'b0;
      end else begin
         lrc_d <= lrc;
         tick  <= 1'b0;
         if (clr || done) begin
            addr    <= '0;
            rep_cnt <= 3'd0;
         end else if (frame) begin
            addr    <= addr_nx[ADDR_W-1:0];
            rep_cnt <= rep_nx;
            tick    <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/audio_ctrl.sv
// Record/playback mode FSM: turns key pulses into recorder commands, latches the
// recording length and drives the playback address generator.
module audio_ctrl
   import audio_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] MAX_ADDR = DEF_MAX_ADDR
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_lrc,
   input  logic              i_key_rec,
   input  logic              i_key_play,
   input  logic              i_key_pause,
   input  logic              i_key_stop,
   input  logic              i_fast,
   input  logic              i_slow,
   input  logic [2:0]        i_speed,
   input  logic [ADDR_W-1:0] i_rec_addr,
   output logic [2:0]        o_state,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   output logic              o_play_en,
   output logic [ADDR_W-1:0] o_play_addr,
   output logic              o_sample_tick,
   output logic [ADDR_W-1:0] o_last_addr,
   output logic              o_sram_we
);

   state_t state, state_nx;
   key_t   key;
   logic   auto_stop, gen_en, gen_clr, gen_done;
   logic   start_nx, pause_nx, stop_nx;

   assign key       = decode_key(i_key_stop, i_key_pause, i_key_rec, i_key_play);
   assign auto_stop = (i_rec_addr == MAX_ADDR);

   // A stop or pause in the same cycle as a frame edge suppresses the address step.
   assign gen_en  = (state == PLAY) && (key != KEY_STOP) && (key != KEY_PAUSE);
   assign gen_clr = (state == IDLE) ||
                    (((state == PLAY) || (state == PLAY_PAUSE)) && (key == KEY_STOP));

   play_addr_gen #(.ADDR_W(ADDR_W)) u_play_addr_gen (
      .clk   (i_clk),
      .rst   (i_rst_n),
      .lrc   (i_lrc),
      .en    (gen_en),
      .clr   (gen_clr),
      .mode  (decode_mode(i_fast, i_slow)),
      .speed (i_speed),
      .last  (o_last_addr),
      .addr  (o_play_addr),
      .tick  (o_sample_tick),
      .done  (gen_done)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         state       <= IDLE;
         o_rec_start <= 1'b0;
         o_rec_pause <= 1'b0;
         o_rec_stop  <= 1'b0;
         o_last_addr <= '0;
      end else begin
         state       <= state_nx;
         o_rec_start <= start_nx;
         o_rec_pause <= pause_nx;
         o_rec_stop  <= stop_nx;
         if (stop_nx) o_last_addr <= i_rec_addr;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (key == KEY_REC)                                   state_nx = REC;
            else if ((key == KEY_PLAY) && (o_last_addr != '0))    state_nx = PLAY;
         end
         REC: begin
            if ((key == KEY_STOP) || auto_stop)                   state_nx = IDLE;
            else if (key == KEY_PAUSE)                            state_nx = REC_PAUSE;
         end
         REC_PAUSE: begin
            if (key == KEY_STOP)                                  state_nx = IDLE;
            else if ((key == KEY_PAUSE) || (key == KEY_REC))      state_nx = REC;
         end
         PLAY: begin
            if (key == KEY_STOP)                                  state_nx = IDLE;
            else if (key == KEY_PAUSE)                            state_nx = PLAY_PAUSE;
            else if (gen_done)                                    state_nx = IDLE;
         end
         PLAY_PAUSE: begin
            if (key == KEY_STOP)                                  state_nx = IDLE;
            else if ((key == KEY_PAUSE) || (key == KEY_PLAY))     state_nx = PLAY;
         end
         default:                                                 state_nx = IDLE;
      endcase
   end

   always_comb begin
      start_nx  = (state_nx == REC) && (state != REC);
      pause_nx  = (state_nx == REC_PAUSE) && (state == REC);
      stop_nx   = (state_nx == IDLE) && ((state == REC) || (state == REC_PAUSE));
      o_state   = state;
      o_sram_we = (state == REC) || (state == REC_PAUSE);
      o_play_en = (state == PLAY);
   end

endmodule

// File: tb/tb_audio_ctrl.sv
// Self-checking bench for audio_ctrl: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the mode/address rules.
module tb_audio_ctrl;

   localparam int AW     = 20;
   localparam int MAXA   = 'hFFFFF;
   localparam int S_IDLE = 0, S_REC = 1, S_RPAUSE = 2, S_PLAY = 3, S_PPAUSE = 4;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_lrc = 1'b0;
   logic          i_key_rec = 1'b0, i_key_play = 1'b0, i_key_pause = 1'b0, i_key_stop = 1'b0;
   logic          i_fast = 1'b0, i_slow = 1'b0;
   logic [2:0]    i_speed = 3'd0;
   logic [AW-1:0] i_rec_addr = '0;
   logic [2:0]    o_state;
   logic          o_rec_start, o_rec_pause, o_rec_stop, o_play_en, o_sample_tick, o_sram_we;
   logic [AW-1:0] o_play_addr, o_last_addr;

   always #5 i_clk = ~i_clk;

   audio_ctrl dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_lrc         (i_lrc),
      .i_key_rec     (i_key_rec),
      .i_key_play    (i_key_play),
      .i_key_pause   (i_key_pause),
      .i_key_stop    (i_key_stop),
      .i_fast        (i_fast),
      .i_slow        (i_slow),
      .i_speed       (i_speed),
      .i_rec_addr    (i_rec_addr),
      .o_state       (o_state),
      .o_rec_start   (o_rec_start),
      .o_rec_pause   (o_rec_pause),
      .o_rec_stop    (o_rec_stop),
      .o_play_en     (o_play_en),
      .o_play_addr   (o_play_addr),
      .o_sample_tick (o_sample_tick),
      .o_last_addr   (o_last_addr),
      .o_sram_we     (o_sram_we)
   );

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: plain integers following the mode and address rules.
   int m_st = 0, m_addr = 0, m_rep = 0, m_last = 0;
   bit m_lrc_d = 0, m_start = 0, m_pause = 0, m_stop = 0, m_tick = 0;

   task automatic model_step();
      int  key;
      int  nxt;
      int  nrep;
      bit  frame;
      m_start = 0; m_pause = 0; m_stop = 0; m_tick = 0;
      if (i_rst_n) begin
         m_st = S_IDLE; m_addr = 0; m_rep = 0; m_last = 0; m_lrc_d = 0;
         return;
      end
      key   = i_key_stop ? 1 : i_key_pause ? 2 : i_key_rec ? 3 : i_key_play ? 4 : 0;
      frame = i_lrc && !m_lrc_d && (m_st == S_PLAY);
      m_lrc_d = i_lrc;
      case (m_st)
         S_IDLE: begin
            if (key == 3) begin m_st = S_REC; m_start = 1; end
            else if (key == 4 && m_last != 0) m_st = S_PLAY;
         end
         S_REC: begin
            if (key == 1 || int'(i_rec_addr) == MAXA) begin
               m_st = S_IDLE; m_stop = 1; m_last = int'(i_rec_addr);
            end else if (key == 2) begin
               m_st = S_RPAUSE; m_pause = 1;
            end
         end
         S_RPAUSE: begin
            if (key == 1) begin m_st = S_IDLE; m_stop = 1; m_last = int'(i_rec_addr); end
            else if (key == 2 || key == 3) begin m_st = S_REC; m_start = 1; end
         end
         S_PLAY: begin
            if (key == 1) begin m_st = S_IDLE; m_addr = 0; m_rep = 0; end
            else if (key == 2) m_st = S_PPAUSE;
            else if (frame) begin
               nrep = m_rep;
               if (i_fast && !i_slow) nxt = m_addr + int'(i_speed) + 1;
               else if (i_slow && !i_fast) begin
                  if (m_rep == int'(i_speed)) begin nxt = m_addr + 1; nrep = 0; end
                  else begin nxt = m_addr; nrep = (m_rep + 1) % 8; end
               end else nxt = m_addr + 1;
               if (nxt >= m_last) begin m_st = S_IDLE; m_addr = 0; m_rep = 0; end
               else begin m_addr = nxt; m_rep = nrep; m_tick = 1; end
            end
         end
         S_PPAUSE: begin
            if (key == 1) begin m_st = S_IDLE; m_addr = 0; m_rep = 0; end
            else if (key == 2 || key == 4) m_st = S_PLAY;
         end
         default: m_st = S_IDLE;
      endcase
   endtask

   task automatic compare_all();
      check("state",     32'(o_state),       32'(m_st));
      check("play_addr", 32'(o_play_addr),   32'(m_addr));
      check("tick",      32'(o_sample_tick), 32'(m_tick));
      check("rec_start", 32'(o_rec_start),   32'(m_start));
      check("rec_pause", 32'(o_rec_pause),   32'(m_pause));
      check("rec_stop",  32'(o_rec_stop),    32'(m_stop));
      check("last_addr", 32'(o_last_addr),   32'(m_last));
      check("sram_we",   32'(o_sram_we),     32'(m_st == S_REC || m_st == S_RPAUSE));
      check("play_en",   32'(o_play_en),     32'(m_st == S_PLAY));
   endtask

   task automatic cyc();
      model_step();
      @(posedge i_clk);
      #1;
      i_key_rec = 0; i_key_play = 0; i_key_pause = 0; i_key_stop = 0;
      compare_all();
   endtask

   task automatic press(input bit rec, input bit play, input bit pause, input bit stop);
      i_key_rec = rec; i_key_play = play; i_key_pause = pause; i_key_stop = stop;
      cyc();
   endtask

   task automatic frame();
      i_lrc = 1; cyc(); cyc();
      i_lrc = 0; cyc(); cyc();
   endtask

   task automatic record_to(input int len);
      press(1, 0, 0, 0);
      i_rec_addr = AW'(len);
      cyc();
      press(0, 0, 0, 1);
      i_rec_addr = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      i_rst_n = 1; cyc(); cyc();
      check("reset_state", 32'(o_state), S_IDLE);
      check("reset_last",  32'(o_last_addr), 0);
      i_rst_n = 0; cyc();

      // Record with a ramping recorder address, then stop at 100.
      press(1, 0, 0, 0);
      check("rec_start_pulse", 32'(o_rec_start), 1);
      for (int a = 1; a <= 100; a++) begin i_rec_addr = AW'(a); cyc(); end
      check("rec_start_one_cycle", 32'(o_rec_start), 0);
      press(0, 0, 0, 1);
      check("rec_stop_pulse", 32'(o_rec_stop), 1);
      check("rec_last", 32'(o_last_addr), 100);
      check("rec_sram_we_low", 32'(o_sram_we), 0);
      cyc();
      check("rec_stop_one_cycle", 32'(o_rec_stop), 0);
      i_rec_addr = '0;

      // Normal playback to the end of the recording.
      press(0, 1, 0, 0);
      for (int e = 1; e <= 99; e++) begin frame(); check("norm_addr", 32'(o_play_addr), 32'(e)); end
      frame();
      check("norm_end_state", 32'(o_state), S_IDLE);
      check("norm_end_addr", 32'(o_play_addr), 0);

      // Fast, 4x.
      i_fast = 1; i_speed = 3'd3;
      press(0, 1, 0, 0);
      for (int e = 1; e <= 24; e++) begin frame(); check("fast_addr", 32'(o_play_addr), 32'(4 * e)); end
      frame();
      check("fast_end_state", 32'(o_state), S_IDLE);

      // Slow, each sample played twice.
      i_fast = 0; i_slow = 1; i_speed = 3'd1;
      press(0, 1, 0, 0);
      for (int e = 1; e <= 6; e++) begin frame(); check("slow_addr", 32'(o_play_addr), 32'(e / 2)); end
      press(0, 0, 0, 1);
      check("slow_stop_addr", 32'(o_play_addr), 0);
      i_slow = 0; i_speed = 3'd0;

      // Pause and resume during playback.
      press(0, 1, 0, 0);
      for (int e = 0; e < 10; e++) frame();
      press(0, 0, 1, 0);
      check("ppause_state", 32'(o_state), S_PPAUSE);
      for (int e = 0; e < 5; e++) frame();
      check("ppause_hold", 32'(o_play_addr), 10);
      press(0, 1, 0, 0);
      frame();
      check("resume_addr", 32'(o_play_addr), 11);
      press(0, 0, 0, 1);

      // Pause/resume while recording, then a three-key stop.
      press(1, 0, 0, 0);
      press(0, 0, 1, 0);
      check("rpause_pulse", 32'(o_rec_pause), 1);
      press(1, 0, 0, 0);
      check("rresume_start", 32'(o_rec_start), 1);
      i_rec_addr = AW'(100);
      press(1, 0, 1, 1);
      check("multi_stop", 32'(o_rec_stop), 1);
      check("multi_no_pause", 32'(o_rec_pause), 0);
      check("multi_state", 32'(o_state), S_IDLE);

      // Auto-stop at the top of memory.
      press(1, 0, 0, 0);
      i_rec_addr = AW'(MAXA);
      cyc();
      check("auto_stop", 32'(o_rec_stop), 1);
      check("auto_last", 32'(o_last_addr), MAXA);
      i_rec_addr = '0;

      // Play with nothing recorded, then reset during playback.
      i_rst_n = 1; cyc(); i_rst_n = 0;
      press(0, 1, 0, 0);
      check("empty_play_ignored", 32'(o_state), S_IDLE);
      record_to(100);
      press(0, 1, 0, 0);
      for (int e = 0; e < 50; e++) frame();
      check("pre_reset_addr", 32'(o_play_addr), 50);
      i_rst_n = 1; cyc(); i_rst_n = 0;
      check("mid_reset_state", 32'(o_state), S_IDLE);
      check("mid_reset_addr", 32'(o_play_addr), 0);
      check("mid_reset_last", 32'(o_last_addr), 0);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 49) == 0) begin
            i_fast  = 1'($urandom_range(0, 1));
            i_slow  = 1'($urandom_range(0, 1));
            i_speed = 3'($urandom_range(0, 7));
         end
         i_key_rec   = ($urandom_range(0, 24) == 0);
         i_key_play  = ($urandom_range(0, 11) == 0);
         i_key_pause = ($urandom_range(0, 29) == 0);
         i_key_stop  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 2) == 0) i_lrc = ~i_lrc;
         i_rec_addr = ($urandom_range(0, 499) == 0) ? AW'(MAXA) : AW'($urandom_range(0, 80));
         i_rst_n    = ($urandom_range(0, 1999) == 0);
         cyc();
      end
      i_rst_n = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
